// File: rtl/dlx_alu_pkg.sv
// Shared types for the multi-cycle DLX EX-stage ALU.
// alu_op_e     : 5-bit opcode space; 0..17 legacy single-cycle ops, 18..20 iterative mul/div.
// fsm_state_e  : sequencing states of dlx_alu_mc.
// md_mode_e    : operating mode of the iterative mul/div unit.
// is_multicycle: true for opcodes handled by the iterative unit.
package dlx_alu_pkg;

  typedef enum logic [4:0] {
    OP_LHI  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_BEQZ = 5'd8,
    OP_BNEZ = 5'd9,
    OP_SEQ  = 5'd10,
    OP_SLE  = 5'd11,
    OP_SLT  = 5'd12,
    OP_SNE  = 5'd13,
    OP_SRA  = 5'd14,
    OP_ADD4 = 5'd15,
    OP_JZ4  = 5'd16,
    OP_JNZ4 = 5'd17,
    OP_MULU = 5'd18,
    OP_DIVU = 5'd19,
    OP_REMU = 5'd20
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } fsm_state_e;

  typedef enum logic {
    MD_MUL,
    MD_DIV
  } md_mode_e;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one result bit per clock.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : load operands a/b and begin WIDTH steps in the given mode
//   abort       : drop any operation in progress (counter cleared)
//   busy        : an operation is stepping
//   done        : the step taken at this edge is the last one
//   product_lo  : low WIDTH bits of a*b (valid once busy has dropped)
//   quotient    : a/b, all ones when b==0
//   remainder   : a%b, equal to a when b==0
module alu_iter_muldiv
  import dlx_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  md_mode_e         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // acc: product (mul) or partial remainder (div)
  // x  : multiplicand shifted left (mul) or dividend/quotient shift register (div)
  // y  : multiplier shifted right (mul) or divisor (div)
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  md_mode_e         mode_q;
  logic [WIDTH:0]   trial;

  always_comb begin
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    trial = {acc_q, x_q[WIDTH-1]};
    if (mode_q == MD_MUL) begin
      if (y_q[0]) acc_d = acc_q + x_q;
      x_d = x_q << 1;
      y_d = y_q >> 1;
    end else begin
      // Difference is below the divisor, so the low WIDTH bits are exact.
      // A zero divisor always subtracts: quotient all ones, remainder = dividend.
      if (trial >= {1'b0, y_q}) begin
        acc_d = trial[WIDTH-1:0] - y_q;
        x_d   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = trial[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MD_MUL;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CntW'(WIDTH - 1);
      mode_q <= mode;
      acc_q  <= '0;
      x_q    <= a;
      y_q    <= b;
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  assign busy       = busy_q;
  assign done       = busy_q && (cnt_q == '0);
  assign product_lo = acc_q;
  assign quotient   = x_q;
  assign remainder  = acc_q;

endmodule

// File: rtl/dlx_alu_mc.sv
// Registered DLX EX-stage ALU with valid/ready handshake and iterative mul/div.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (op, op1, op2)
//   flush                : squash in-flight operation and pending result
//   out_valid / out_ready: result handshake (res, ZF)
// Single-cycle ops register their result at the accept edge; MULU/DIVU/REMU
// occupy the unit for WIDTH+1 edges after the accept edge.
module dlx_alu_mc
  import dlx_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             ZF
);

  fsm_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, res_sc, res_md;
  logic             zf_q, zf_d, zf_sc;
  logic             out_valid_q, out_valid_d;
  logic [4:0]       op_q, op_d;
  logic             accept;
  logic             md_start, md_busy, md_done;
  md_mode_e         md_mode;
  logic [WIDTH-1:0] md_prod, md_quot, md_rem;
  logic [SHAMT_W-1:0] shamt;
  alu_op_e          op_e;

  assign op_e     = alu_op_e'(op);
  assign shamt    = op2[SHAMT_W-1:0];
  assign in_ready = (state_q == IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_mode  = (op == OP_MULU) ? MD_MUL : MD_DIV;

  // Single-cycle datapath; undefined codes yield zero.
  always_comb begin
    res_sc = '0;
    case (op_e)
      OP_LHI:  res_sc = op2 << (WIDTH / 2);
      OP_ADD:  res_sc = op1 + op2;
      OP_SUB:  res_sc = op1 - op2;
      OP_AND:  res_sc = op1 & op2;
      OP_OR:   res_sc = op1 | op2;
      OP_XOR:  res_sc = op1 ^ op2;
      OP_SLL:  res_sc = op1 << shamt;
      OP_SRL:  res_sc = op1 >> shamt;
      OP_SRA:  res_sc = $unsigned($signed(op1) >>> shamt);
      OP_BEQZ: res_sc = (op1 == '0) ? op2 : '0;
      OP_BNEZ: res_sc = (op1 != '0) ? op2 : '0;
      OP_SEQ:  res_sc = {{(WIDTH-1){1'b0}}, op1 == op2};
      OP_SLE:  res_sc = {{(WIDTH-1){1'b0}}, op1 <= op2};
      OP_SLT:  res_sc = {{(WIDTH-1){1'b0}}, op1 < op2};
      OP_SNE:  res_sc = {{(WIDTH-1){1'b0}}, op1 != op2};
      OP_ADD4: res_sc = op1 + WIDTH'(4);
      OP_JZ4:  res_sc = (op1 == '0) ? op2 : WIDTH'(4);
      OP_JNZ4: res_sc = (op1 != '0) ? op2 : WIDTH'(4);
      default: res_sc = '0;
    endcase
    // Branch ops report the branch condition rather than a zero result.
    zf_sc = (res_sc == '0);
    if (op_e == OP_BEQZ) zf_sc = (op1 != '0);
    if (op_e == OP_BNEZ) zf_sc = (op1 == '0);
  end

  always_comb begin
    case (op_q)
      OP_DIVU: res_md = md_quot;
      OP_REMU: res_md = md_rem;
      default: res_md = md_prod;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    zf_d        = zf_q;
    op_d        = op_q;
    out_valid_d = out_valid_q && !out_ready;
    md_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_multicycle(op)) begin
            md_start = 1'b1;
            op_d     = op;
            state_d  = ITER;
          end else begin
            res_d       = res_sc;
            zf_d        = zf_sc;
            out_valid_d = 1'b1;
          end
        end
      end
      ITER: begin
        if (md_done) begin
          state_d = DONE;
        end else if (!md_busy) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        res_d       = res_md;
        zf_d        = (res_md == '0);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      md_start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      zf_q        <= 1'b0;
      out_valid_q <= 1'b0;
      op_q        <= 5'd0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      zf_q        <= zf_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
    end
  end

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .abort     (flush),
    .mode      (md_mode),
    .a         (op1),
    .b         (op2),
    .busy      (md_busy),
    .done      (md_done),
    .product_lo(md_prod),
    .quotient  (md_quot),
    .remainder (md_rem)
  );

  assign res       = res_q;
  assign ZF        = zf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dlx_alu_mc.sv
// Bench for dlx_alu_mc: directed and random requests checked against an
// arithmetic reference model. Two instances share the stimulus, one with
// 3-bit shift amounts and one with 5-bit shift amounts.
module tb_dlx_alu_mc;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [4:0]  op;
  logic [31:0] op1, op2;
  logic        in_ready, out_valid, zf;
  logic [31:0] res;
  logic        in_ready5, out_valid5, zf5;
  logic [31:0] res5;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] got_res, got_res5;
  logic        got_zf;

  always #5 clk = ~clk;

  dlx_alu_mc #(.WIDTH(32), .SHAMT_W(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .op1(op1),
    .op2(op2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .res(res), .ZF(zf)
  );

  dlx_alu_mc #(.WIDTH(32), .SHAMT_W(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .op(op), .op1(op1),
    .op2(op2), .flush(flush), .out_valid(out_valid5), .out_ready(out_ready), .res(res5),
    .ZF(zf5)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout, required $finish before limit");
    $fatal(1);
  end

  // Returns {ZF, res} for one request.
  function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] a, b,
                                        input int shw);
    logic [31:0] r;
    logic        z;
    logic [63:0] p;
    int          sh;
    sh = int'(b & ((32'd1 << shw) - 32'd1));
    p  = {32'd0, a} * {32'd0, b};
    case (o)
      5'd0:  r = b << 16;
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a & b;
      5'd4:  r = a | b;
      5'd5:  r = a ^ b;
      5'd6:  r = a << sh;
      5'd7:  r = a >> sh;
      5'd8:  r = (a == 0) ? b : 32'd0;
      5'd9:  r = (a != 0) ? b : 32'd0;
      5'd10: r = (a == b) ? 32'd1 : 32'd0;
      5'd11: r = (a <= b) ? 32'd1 : 32'd0;
      5'd12: r = (a < b) ? 32'd1 : 32'd0;
      5'd13: r = (a != b) ? 32'd1 : 32'd0;
      5'd14: r = $unsigned($signed(a) >>> sh);
      5'd15: r = a + 32'd4;
      5'd16: r = (a == 0) ? b : 32'd4;
      5'd17: r = (a != 0) ? b : 32'd4;
      5'd18: r = p[31:0];
      5'd19: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd20: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    z = (r == 0);
    if (o == 5'd8) z = (a != 0);
    if (o == 5'd9) z = (a == 0);
    return {z, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request with out_ready high, wait for its result, compare to the
  // model, then let it drain. Called and returning at posedge+1.
  task automatic send(input string tag, input logic [4:0] o, input logic [31:0] a, b);
    logic [32:0] m3, m5;
    int          lat, guard;
    bit          multi, stall_ok;
    m3    = model(o, a, b, 3);
    m5    = model(o, a, b, 5);
    multi = (o >= 5'd18) && (o <= 5'd20);
    op = o; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #2; guard++;
    end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Edges after the accept edge until out_valid: 0 single-cycle, WIDTH+1 mul/div.
    lat = 0; stall_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) stall_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, 32'(lat), multi ? 32'd33 : 32'd0);
    if (multi) chk({tag, " stall"}, 32'(stall_ok), 32'd1);
    got_res = res; got_zf = zf; got_res5 = res5;
    chk({tag, " res"}, res, m3[31:0]);
    chk({tag, " zf"}, 32'(zf), 32'(m3[32]));
    chk({tag, " res5"}, res5, m5[31:0]);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    logic [4:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = 5'd0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset res", res, 32'd0);
    chk("reset zf", 32'(zf), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed cases with literal expectations.
    send("add wrap", 5'd1, 32'hFFFF_FFFF, 32'd1);
    chk("add wrap lit", got_res, 32'd0);
    chk("add wrap zf lit", 32'(got_zf), 32'd1);
    send("sll 9", 5'd6, 32'd1, 32'd9);
    chk("sll 9 lit", got_res, 32'd2);
    chk("sll 9 w5 lit", got_res5, 32'h200);
    send("beqz", 5'd8, 32'd0, 32'h55);
    chk("beqz lit", got_res, 32'h55);
    chk("beqz zf lit", 32'(got_zf), 32'd0);
    send("bnez", 5'd9, 32'd0, 32'h55);
    chk("bnez zf lit", 32'(got_zf), 32'd1);
    send("jz4", 5'd16, 32'd3, 32'h77);
    chk("jz4 lit", got_res, 32'd4);
    send("sra", 5'd14, 32'h8000_0000, 32'd3);
    send("lhi", 5'd0, 32'd0, 32'h0000_ABCD);
    send("op25", 5'd25, 32'h1234, 32'h5678);
    send("mulu", 5'd18, 32'h1_0000, 32'h1_0003);
    chk("mulu lit", got_res, 32'h3_0000);
    send("divu", 5'd19, 32'd100, 32'd7);
    chk("divu lit", got_res, 32'd14);
    send("remu", 5'd20, 32'd100, 32'd7);
    chk("remu lit", got_res, 32'd2);
    send("divu0", 5'd19, 32'd5, 32'd0);
    chk("divu0 lit", got_res, 32'hFFFF_FFFF);
    send("remu0", 5'd20, 32'd5, 32'd0);
    chk("remu0 lit", got_res, 32'd5);

    // Back-pressure: second request stalls until the first result is taken.
    out_ready = 1'b0; op = 5'd1; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1;
    #1;
    chk("b2b first in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b first valid", 32'(out_valid), 32'd1);
    chk("b2b first res", res, 32'd3);
    op1 = 32'd4; op2 = 32'd5;
    #1;
    chk("b2b stall in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b hold valid", 32'(out_valid), 32'd1);
    chk("b2b hold res", res, 32'd3);
    out_ready = 1'b1;
    #1;
    chk("b2b release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b second valid", 32'(out_valid), 32'd1);
    chk("b2b second res", res, 32'd9);
    @(posedge clk); #1;
    chk("b2b drained", 32'(out_valid), 32'd0);

    // Flush ten cycles into a divide, with a request presented in the flush cycle.
    op = 5'd19; op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
    #1;
    chk("flush div in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 5'd1; op1 = 32'd7; op2 = 32'd8;
    #1;
    chk("flush blocks in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush no result", 32'(seen), 32'd0);
    send("post flush add", 5'd1, 32'd2, 32'd3);
    chk("post flush lit", got_res, 32'd5);

    // Reset ten cycles into a divide.
    op = 5'd19; op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst mid out_valid", 32'(out_valid), 32'd0);
    chk("rst mid res", res, 32'd0);
    chk("rst mid in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst no result", 32'(seen), 32'd0);

    // Random requests over the full opcode space.
    for (int i = 0; i < 60; i++) begin
      ro = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      send("random", ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
